// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

  // Encoding follows the order the states are listed in the design notes,
  // so the debug state output reads 0 = FETCH ... 14 = JUMP.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ANDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_SLTIEX  = 4'd12,
    S_IMMWB   = 4'd13,
    S_JUMP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop: what the ALU decoder should do this state
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - ALU decoder: aluop plus funct to alucontrol
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_bad_funct
);

  // Fixed ops for ADD/SUB; funct decode otherwise, flagging unknown functs
  always_comb begin
    o_alucontrol = ALU_ADD;
    o_bad_funct  = 1'b0;
    case (i_aluop)
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_bad_funct  = 1'b1;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM sequencing the shared-memory multicycle MIPS datapath
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [5:0]           i_op,
  input  logic [5:0]           i_funct,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_pcen,
  output logic                 o_iord,
  output logic                 o_irwrite,
  output logic                 o_memwrite,
  output logic                 o_regwrite,
  output logic                 o_regdst,
  output logic                 o_memtoreg,
  output logic                 o_alusrca,
  output logic [1:0]           o_alusrcb,
  output logic                 o_zeroext,
  output logic [1:0]           o_pcsrc,
  output logic [ALUCTRL_W-1:0] o_alucontrol,
  output logic                 o_illegal,
  output logic [STATE_W-1:0]   o_state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ready;
  logic       w_pcen, w_irwrite, w_memwrite, w_regwrite, w_illegal_op;
  logic [1:0] w_aluop;
  logic [5:0] w_dec_funct;
  logic [2:0] w_aluctrl;
  logic       w_bad_funct;

  assign w_mem_ready = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;

  mips_alu_dec u_alu_dec (
    .i_aluop      (w_aluop),
    .i_funct      (w_dec_funct),
    .o_alucontrol (w_aluctrl),
    .o_bad_funct  (w_bad_funct)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state and Moore outputs; immediate ops reuse the funct decoder
  // by presenting the matching R-type funct code
  always_comb begin
    w_next       = r_state;
    w_pcen       = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regwrite   = 1'b0;
    w_illegal_op = 1'b0;
    o_iord       = 1'b0;
    o_regdst     = 1'b0;
    o_memtoreg   = 1'b0;
    o_alusrca    = 1'b0;
    o_alusrcb    = SRCB_B;
    o_zeroext    = 1'b0;
    o_pcsrc      = PCSRC_ALU;
    w_aluop      = ALUOP_ADD;
    w_dec_funct  = i_funct;
    case (r_state)
      S_FETCH: begin
        o_alusrcb = SRCB_FOUR;
        w_pcen    = w_mem_ready;
        w_irwrite = w_mem_ready;
        if (w_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        o_alusrcb = SRCB_BRIMM;
        case (i_op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_RTYPEEX;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_ANDI:        w_next = S_ANDIEX;
          OP_ORI:         w_next = S_ORIEX;
          OP_SLTI:        w_next = S_SLTIEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        w_next    = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_iord = 1'b1;
        if (w_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (w_mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        o_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        o_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        o_pcsrc   = PCSRC_ALUOUT;
        w_pcen    = i_zero ^ i_op[0];
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        w_next    = S_IMMWB;
      end
      S_ANDIEX: begin
        o_alusrca   = 1'b1;
        o_alusrcb   = SRCB_IMM;
        o_zeroext   = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_dec_funct = F_AND;
        w_next      = S_IMMWB;
      end
      S_ORIEX: begin
        o_alusrca   = 1'b1;
        o_alusrcb   = SRCB_IMM;
        o_zeroext   = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_dec_funct = F_OR;
        w_next      = S_IMMWB;
      end
      S_SLTIEX: begin
        o_alusrca   = 1'b1;
        o_alusrcb   = SRCB_IMM;
        w_aluop     = ALUOP_FUNCT;
        w_dec_funct = F_SLT;
        w_next      = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        o_pcsrc = PCSRC_JUMP;
        w_pcen  = 1'b1;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing writes while reset is held
  assign o_pcen       = i_reset & w_pcen;
  assign o_irwrite    = i_reset & w_irwrite;
  assign o_memwrite   = i_reset & w_memwrite;
  assign o_regwrite   = i_reset & w_regwrite;
  assign o_illegal    = i_reset & (w_illegal_op | ((r_state == S_RTYPEEX) & w_bad_funct));
  assign o_alucontrol = ALUCTRL_W'(w_aluctrl);
  assign o_state      = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_pcen(pcen), .o_iord(iord), .o_irwrite(irwrite),
    .o_memwrite(memwrite), .o_regwrite(regwrite), .o_regdst(regdst),
    .o_memtoreg(memtoreg), .o_alusrca(alusrca), .o_alusrcb(alusrcb),
    .o_zeroext(zeroext), .o_pcsrc(pcsrc), .o_alucontrol(alucontrol),
    .o_illegal(illegal), .o_state(state)
  );

  // State numbers in the order the states are listed
  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3, T_MEMWB = 4;
  localparam int T_MEMWR = 5, T_RTYPEEX = 6, T_ALUWB = 7, T_BRANCH = 8, T_ADDIEX = 9;
  localparam int T_ANDIEX = 10, T_ORIEX = 11, T_SLTIEX = 12, T_IMMWB = 13, T_JUMP = 14;

  localparam logic [5:0] B_LW = 6'b100011, B_SW = 6'b101011, B_R = 6'b000000;
  localparam logic [5:0] B_BEQ = 6'b000100, B_BNE = 6'b000101, B_ADDI = 6'b001000;
  localparam logic [5:0] B_ANDI = 6'b001100, B_ORI = 6'b001101, B_SLTI = 6'b001010;
  localparam logic [5:0] B_J = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } step_t;

  step_t plan[$];
  out_t  sb[$];
  int    n_vec = 0;
  int    n_miss = 0;

  function automatic out_t base(input int st);
    out_t r = '0;
    r.st   = 4'(st);
    r.aluc = 3'b010;
    return r;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // {illegal, alucontrol} for an R-type funct
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b1010;
    endcase
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic rdy, input out_t e);
    step_t s;
    s.op = o; s.funct = f; s.zero = z; s.rdy = rdy; s.exp = e;
    plan.push_back(s);
  endtask

  // Reference model: the cycle-by-cycle plan for one instruction.
  // stall_f / stall_m = cycles mem_ready stays low in fetch / memory access;
  // bz < 0 means random zero flag in the branch cycle.
  task automatic build_instr(input logic [5:0] o, input logic [5:0] f,
                             input int stall_f, input int stall_m, input int bz);
    out_t e;
    logic z, rdy, legal;
    logic [3:0] ra;
    for (int i = 0; i <= stall_f; i++) begin
      rdy = (i == stall_f);
      e = base(T_FETCH); e.alusrcb = 2'b01; e.pcen = rdy; e.irwrite = rdy;
      add(o, f, rbit(), rdy, e);
    end
    legal = o inside {B_LW, B_SW, B_R, B_BEQ, B_BNE, B_ADDI, B_ANDI, B_ORI, B_SLTI, B_J};
    e = base(T_DECODE); e.alusrcb = 2'b11; e.illegal = !legal;
    add(o, f, rbit(), rbit(), e);
    if (!legal) return;
    case (o)
      B_LW, B_SW: begin
        e = base(T_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        add(o, f, rbit(), rbit(), e);
        for (int i = 0; i <= stall_m; i++) begin
          e = base(o == B_LW ? T_MEMRD : T_MEMWR); e.iord = 1'b1; e.memwrite = (o == B_SW);
          add(o, f, rbit(), i == stall_m, e);
        end
        if (o == B_LW) begin
          e = base(T_MEMWB); e.memtoreg = 1'b1; e.regwrite = 1'b1;
          add(o, f, rbit(), rbit(), e);
        end
      end
      B_R: begin
        ra = rtype_alu(f);
        e = base(T_RTYPEEX); e.alusrca = 1'b1; e.aluc = ra[2:0]; e.illegal = ra[3];
        add(o, f, rbit(), rbit(), e);
        e = base(T_ALUWB); e.regdst = 1'b1; e.regwrite = 1'b1;
        add(o, f, rbit(), rbit(), e);
      end
      B_BEQ, B_BNE: begin
        z = (bz < 0) ? rbit() : 1'(bz);
        e = base(T_BRANCH); e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (o == B_BNE) ? !z : z;
        add(o, f, z, rbit(), e);
      end
      B_J: begin
        e = base(T_JUMP); e.pcsrc = 2'b10; e.pcen = 1'b1;
        add(o, f, rbit(), rbit(), e);
      end
      default: begin
        e = base(o == B_ADDI ? T_ADDIEX : o == B_ANDI ? T_ANDIEX : o == B_ORI ? T_ORIEX : T_SLTIEX);
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        e.zeroext = (o == B_ANDI) || (o == B_ORI);
        e.aluc = (o == B_ANDI) ? 3'b000 : (o == B_ORI) ? 3'b001 : (o == B_SLTI) ? 3'b111 : 3'b010;
        add(o, f, rbit(), rbit(), e);
        e = base(T_IMMWB); e.regwrite = 1'b1;
        add(o, f, rbit(), rbit(), e);
      end
    endcase
  endtask

  // Apply up to max_steps planned cycles; called at posedge+1 with the DUT in FETCH
  task automatic run_plan(input int max_steps);
    step_t s;
    int n = 0;
    while (plan.size() != 0 && n < max_steps) begin
      s = plan.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      sb.push_back(s.exp);
      @(posedge clk); #1;
      n++;
    end
  endtask

  function automatic out_t sample();
    out_t a;
    a.st = state; a.pcen = pcen; a.iord = iord; a.irwrite = irwrite; a.memwrite = memwrite;
    a.regwrite = regwrite; a.regdst = regdst; a.memtoreg = memtoreg; a.alusrca = alusrca;
    a.alusrcb = alusrcb; a.zeroext = zeroext; a.pcsrc = pcsrc; a.aluc = alucontrol;
    a.illegal = illegal;
    return a;
  endfunction

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared mid-cycle
  always @(negedge clk) begin
    out_t e, a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = sample();
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL cycle vec%0d (exp state %0d) got %h expected %h", n_vec, e.st, a, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] o, f;
    int k;
    // reset held with mem_ready high: strobes must stay low
    mem_ready = 1'b1; op = B_LW;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_state", 8'(state), 8'(T_FETCH));
    check1("reset_pcen", 8'(pcen), 8'd0);
    check1("reset_irwrite", 8'(irwrite), 8'd0);
    check1("reset_strobes", 8'({memwrite, regwrite, illegal}), 8'd0);
    reset = 1'b1;

    // directed cases
    build_instr(B_LW, 6'h00, 0, 0, -1);
    build_instr(B_SW, 6'h00, 0, 3, -1);
    build_instr(B_BNE, 6'h00, 0, 0, 0);
    build_instr(B_BEQ, 6'h00, 0, 0, 0);
    build_instr(B_ORI, 6'h15, 0, 0, -1);
    build_instr(B_ADDI, 6'h00, 5, 0, -1);
    build_instr(6'b111111, 6'h00, 0, 0, -1);
    build_instr(B_R, 6'b100010, 0, 0, -1);
    build_instr(B_R, 6'b111000, 0, 0, -1);
    build_instr(B_J, 6'h00, 0, 0, -1);
    run_plan(1000);

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 11);
      case (k)
        0: o = B_LW;   1: o = B_SW;   2: o = B_R;    3: o = B_BEQ;
        4: o = B_BNE;  5: o = B_ADDI; 6: o = B_ANDI; 7: o = B_ORI;
        8: o = B_SLTI; 9: o = B_J;    10: o = 6'b111111;
        default: o = 6'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
        3: f = 6'b100101; 4: f = 6'b101010; default: f = 6'($urandom);
      endcase
      build_instr(o, f, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                  $urandom_range(0, 3), -1);
      run_plan(1000);
    end

    // reset during a stalled sw: write strobe must drop at once
    build_instr(B_SW, 6'h00, 0, 6, -1);
    run_plan(5);
    plan.delete();
    mem_ready = 1'b0;
    #1;
    check1("sw_stalled_memwrite", 8'(memwrite), 8'd1);
    reset = 1'b0;
    #1;
    check1("abort_memwrite", 8'(memwrite), 8'd0);
    check1("abort_state", 8'(state), 8'(T_FETCH));
    check1("abort_regwrite", 8'(regwrite), 8'd0);
    @(posedge clk); #1;
    check1("abort_held_state", 8'(state), 8'(T_FETCH));
    reset = 1'b1;
    build_instr(B_LW, 6'h00, 1, 1, -1);
    build_instr(B_J, 6'h00, 0, 0, -1);
    run_plan(1000);

    for (int w = 0; w < 4 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
